// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP datapath units.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic signed [9:0] BIAS_S = 10'sd127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == '0);
    endfunction

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input fp32_t x);
        return x.exp == '0;
    endfunction

endpackage

// File: rtl/fp_multiplier_if.sv
// Operand/result bundle for the binary32 multiplier; no handshake.
interface fp_multiplier_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;

    modport master (output a, output b, input  result);
    modport slave  (input  a, input  b, output result);
endinterface

// File: rtl/fp_mul_round.sv
// Normalises a 48-bit mantissa product, rounds to nearest-even and saturates
// the exponent to signed infinity or flushed signed zero.
module fp_mul_round
    import fp32_pkg::*;
(
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    input  logic              sign,
    output logic [31:0]       word
);

    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic              g, r, s, inc;
    logic signed [9:0] e;
    logic [22:0]       frac;

    always_comb begin
        mant = '0;
        g    = 1'b0;
        r    = 1'b0;
        s    = 1'b0;
        e    = exp_in;
        if (prod[47]) begin
            mant = prod[47:24];
            g    = prod[23];
            r    = prod[22];
            s    = |prod[21:0];
            e    = exp_in + 10'sd1;
        end else begin
            mant = prod[46:23];
            g    = prod[22];
            r    = prod[21];
            s    = |prod[20:0];
        end

        inc    = g & (r | s | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, inc};

        // Carry out of rounding leaves 1.000..., so only the exponent moves.
        if (mant_r[24]) begin
            e    = e + 10'sd1;
            frac = '0;
        end else begin
            frac = mant_r[22:0];
        end

        if (e >= 10'sd255)
            word = {sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            word = {sign, 31'd0};
        else
            word = {sign, e[7:0], frac};
    end

endmodule

// File: rtl/fp_multiplier.sv
// Binary32 multiplier: classification, special-case mux, 24x24 mantissa
// multiply and a single output register (1-cycle latency, 1/cycle throughput).
module fp_multiplier
    import fp32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fp_multiplier_if.slave  bus
);

    fp32_t             fa, fb;
    logic              sgn;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic [31:0]       rnd_word;
    logic [31:0]       nxt;
    logic [31:0]       result_q;

    assign fa  = bus.a;
    assign fb  = bus.b;
    assign sgn = fa.sign ^ fb.sign;

    assign a_nan  = is_nan(fa);
    assign b_nan  = is_nan(fb);
    assign a_inf  = is_inf(fa);
    assign b_inf  = is_inf(fb);
    assign a_zero = is_zero(fa);
    assign b_zero = is_zero(fb);

    assign prod = {24'd0, 1'b1, fa.frac} * {24'd0, 1'b1, fb.frac};

    // Ten signed bits hold ea+eb-127 plus two increments without wrapping.
    assign exp_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - BIAS_S;

    fp_mul_round u_round (
        .prod   (prod),
        .exp_in (exp_sum),
        .sign   (sgn),
        .word   (rnd_word)
    );

    always_comb begin
        nxt = rnd_word;
        if (a_nan || b_nan)
            nxt = QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            nxt = QNAN;
        else if (a_inf || b_inf)
            nxt = {sgn, POS_INF[30:0]};
        else if (a_zero || b_zero)
            nxt = {sgn, 31'd0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            result_q <= '0;
        else
            result_q <= nxt;
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: directed vectors plus randomized
// back-to-back operands against an integer-arithmetic reference model.
module tb_fp_multiplier;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fp_multiplier_if bus ();

    fp_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact product as an integer, rounded by comparing the
    // discarded remainder against one half ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        int                ea, eb, e, sh;
        logic [22:0]       fa, fb;
        longint unsigned   p, q, rem, half;
        logic [31:0]       res;
        bit                a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        sgn = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        fa  = a[22:0];
        fb  = b[22:0];
        a_nan = (ea == 255) && (fa != 0);
        b_nan = (eb == 255) && (fb != 0);
        a_inf = (ea == 255) && (fa == 0);
        b_inf = (eb == 255) && (fb == 0);
        a_z   = (ea == 0);
        b_z   = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if ((a_inf && b_z) || (b_inf && a_z)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {sgn, 8'hFF, 23'd0};
        if (a_z || b_z) return {sgn, 31'd0};
        p  = (64'h80_0000 + 64'(fa)) * (64'h80_0000 + 64'(fb));
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ea + eb - 127 + ((sh == 24) ? 1 : 0);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e <= 0)   return {sgn, 31'd0};
        res = {sgn, e[7:0], q[22:0]};
        return res;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                      32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0123, 32'h3F80_0000};
        logic [31:0] v;
        int mode;
        mode = int'($urandom_range(0, 9));
        v    = $urandom;
        if (mode == 0)
            v = specials[$urandom_range(0, 7)];
        else if (mode <= 2)
            v = $urandom;
        else if (mode <= 4)
            v[30:23] = 8'($urandom_range(1, 254));
        else
            v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    localparam int ND = 12;
    logic [31:0] dir_tbl [ND][3] = '{
        '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000},
        '{32'hBF80_0000, 32'h3FC0_0000, 32'hBFC0_0000},
        '{32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000},
        '{32'hBF00_0000, 32'h4020_0000, 32'hBFA0_0000},
        '{32'h3E4C_CCCD, 32'h3E4C_CCCD, 32'h3D23_D70B},
        '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000},
        '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000},
        '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000},
        '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000},
        '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000},
        '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000},
        '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002}
    };

    initial begin
        logic [31:0] ra, rb, held;
        n_tests = 0;
        n_fail  = 0;

        // Reset must override valid operands on the same edge.
        rst_n = 1'b0;
        bus.a = 32'h3F80_0000;
        bus.b = 32'h3F80_0000;
        @(posedge clk); #1;
        chk("reset", bus.result, 32'h0000_0000);
        rst_n = 1'b1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < ND; i++) begin
            bus.a = dir_tbl[i][0];
            bus.b = dir_tbl[i][1];
            @(posedge clk); #1;
            chk($sformatf("dir%0d %h*%h", i, dir_tbl[i][0], dir_tbl[i][1]), bus.result, dir_tbl[i][2]);
        end

        // Result must hold between edges while operands change.
        held  = bus.result;
        bus.a = 32'h4040_0000;
        bus.b = 32'h4040_0000;
        #3;
        chk("hold", bus.result, held);
        @(posedge clk); #1;
        chk("after_hold 3*3", bus.result, 32'h4110_0000);

        // Randomized back-to-back stream with a reset pulse in the middle.
        for (int i = 0; i < 400; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            bus.a = ra;
            bus.b = rb;
            if (i == 200) rst_n = 1'b0;
            @(posedge clk); #1;
            if (i == 200) begin
                chk("midreset", bus.result, 32'h0000_0000);
                rst_n = 1'b1;
            end else begin
                chk($sformatf("rnd%0d %h*%h", i, ra, rb), bus.result, ref_mul(ra, rb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
